switch_logic_led: RTL and testbench

//  Parametrised switch-to-LED logic stage for the board I/O path.

---
 rtl/switch_logic_led.sv | 98 +++++++++
 tb/tb_switch_logic_led.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_logic_led.sv
// Switch-to-LED logic stage: 2-flop sync, per-bit debounce, selectable reduction to one LED,
// rising-edge pulse and saturating rise counter.
module switch_logic_led #(
    parameter int unsigned N_SW       = 2,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw,
    input  logic [2:0]       mode,
    input  logic             clr,
    output logic [N_SW-1:0]  sw_db,
    output logic             l,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [N_SW-1:0]  s1, s2, sw_db_prev;
    logic [DW-1:0]    deb_cnt [N_SW];
    logic             l_next, rise, l_rise;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_db <= '0;
            for (int i = 0; i < int'(N_SW); i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_SW); i++) begin
                if (s2[i] == sw_db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    sw_db[i]   <= s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Simultaneous rises of several bits collapse into a single toggle.
    assign rise = |(sw_db & ~sw_db_prev);

    always_comb begin
        l_next = l;
        unique case (mode)
            3'd0: l_next = |sw_db;
            3'd1: l_next = ~|sw_db;
            3'd2: l_next = &sw_db;
            3'd3: l_next = ~&sw_db;
            3'd4: l_next = ^sw_db;
            3'd5: l_next = ~^sw_db;
            3'd6: l_next = rise ? ~l : l;
            3'd7: l_next = sw_db[0];
        endcase
    end

    assign l_rise = l_next & ~l;

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (l_rise && (cnt != {CNT_W{1'b1}})) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_db_prev <= '0;
            l          <= 1'b0;
            edge_pulse <= 1'b0;
            cnt        <= '0;
        end else begin
            sw_db_prev <= sw_db;
            l          <= l_next;
            edge_pulse <= l_rise;
            cnt        <= cnt_next;
        end
    end

endmodule

// File: tb/tb_switch_logic_led.sv
// Directed bench for switch_logic_led: N_SW=2, DEB_CYCLES=4, with CNT_W=8 and CNT_W=2 instances.
module tb_switch_logic_led;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] sw = 2'b00;
    logic [2:0] mode = 3'd0;
    logic       clr = 1'b0;
    logic [1:0] sw_db, sw_db2;
    logic       l, l2, ep, ep2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    int nv = 0;
    int nf = 0;

    always #5 clk = ~clk;

    switch_logic_led #(.N_SW(2), .DEB_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .clr(clr),
        .sw_db(sw_db), .l(l), .edge_pulse(ep), .cnt(cnt)
    );

    switch_logic_led #(.N_SW(2), .DEB_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .clr(clr),
        .sw_db(sw_db2), .l(l2), .edge_pulse(ep2), .cnt(cnt2)
    );

    // After tick(n) the state reflects n edges; sampling is 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [2:0] m);
        rst_n = 1'b0;
        sw    = 2'b00;
        clr   = 1'b0;
        tick(2);
        mode  = m;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        mode = 3'd1;
        #3 rst_n = 1'b0;
        tick(2);
        nv++; if (sw_db !== 2'b00) begin nf++; $display("FAIL rst_sw_db got %b want 00", sw_db); end
        nv++; if (l !== 1'b0) begin nf++; $display("FAIL rst_l got %b want 0", l); end
        nv++; if (ep !== 1'b0) begin nf++; $display("FAIL rst_edge got %b want 0", ep); end
        nv++; if (cnt !== 8'd0) begin nf++; $display("FAIL rst_cnt got %0d want 0", cnt); end
        rst_n = 1'b1;
        tick(1);
        nv++; if (l !== 1'b1) begin nf++; $display("FAIL nor_first_l got %b want 1", l); end
        nv++; if (ep !== 1'b1) begin nf++; $display("FAIL nor_first_edge got %b want 1", ep); end
        nv++; if (cnt !== 8'd1) begin nf++; $display("FAIL nor_first_cnt got %0d want 1", cnt); end
        tick(1);
        nv++; if (ep !== 1'b0) begin nf++; $display("FAIL nor_edge_drop got %b want 0", ep); end
        tick(3);
        nv++; if (l !== 1'b1) begin nf++; $display("FAIL nor_hold_l got %b want 1", l); end
        nv++; if (cnt !== 8'd1) begin nf++; $display("FAIL nor_hold_cnt got %0d want 1", cnt); end
    endtask

    task automatic test_debounce;
        do_reset(3'd0);
        tick(2);
        sw = 2'b01;
        tick(5);
        nv++; if (sw_db !== 2'b00) begin nf++; $display("FAIL deb_early got %b want 00", sw_db); end
        tick(1);
        nv++; if (sw_db !== 2'b01) begin nf++; $display("FAIL deb_accept got %b want 01", sw_db); end
        nv++; if (l !== 1'b0) begin nf++; $display("FAIL deb_l_lag got %b want 0", l); end
        tick(1);
        nv++; if (l !== 1'b1) begin nf++; $display("FAIL or_l got %b want 1", l); end
        nv++; if (ep !== 1'b1) begin nf++; $display("FAIL or_edge got %b want 1", ep); end
        nv++; if (cnt !== 8'd1) begin nf++; $display("FAIL or_cnt got %0d want 1", cnt); end
        tick(1);
        nv++; if (ep !== 1'b0) begin nf++; $display("FAIL or_edge_one got %b want 0", ep); end
        sw = 2'b00;
        tick(10);
        nv++; if (l !== 1'b0) begin nf++; $display("FAIL or_release got %b want 0", l); end
    endtask

    task automatic test_glitch;
        logic [13:0] pat [2];
        pat[0] = 14'b00000000000111;
        pat[1] = 14'b00000000111011;
        do_reset(3'd0);
        tick(2);
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 14; t++) begin
                sw = {1'b0, pat[p][t]};
                tick(1);
                nv++;
                if (sw_db !== 2'b00 || l !== 1'b0 || ep !== 1'b0) begin
                    nf++;
                    $display("FAIL glitch p%0d t%0d got db=%b l=%b e=%b want 00/0/0",
                             p, t, sw_db, l, ep);
                end
            end
        end
    endtask

    task automatic test_toggle;
        do_reset(3'd6);
        tick(2);
        sw = 2'b01;
        tick(7);
        nv++; if (l !== 1'b1) begin nf++; $display("FAIL tog1_l got %b want 1", l); end
        nv++; if (ep !== 1'b1) begin nf++; $display("FAIL tog1_edge got %b want 1", ep); end
        tick(3);
        sw = 2'b00;
        tick(10);
        nv++; if (l !== 1'b1) begin nf++; $display("FAIL tog_rel_l got %b want 1", l); end
        sw = 2'b01;
        tick(7);
        nv++; if (l !== 1'b0) begin nf++; $display("FAIL tog2_l got %b want 0", l); end
        nv++; if (cnt !== 8'd1) begin nf++; $display("FAIL tog2_cnt got %0d want 1", cnt); end
        tick(3);
        sw = 2'b00;
        tick(10);
        sw = 2'b11;
        tick(7);
        nv++; if (l !== 1'b1) begin nf++; $display("FAIL tog_both_l got %b want 1", l); end
        nv++; if (cnt !== 8'd2) begin nf++; $display("FAIL tog_both_cnt got %0d want 2", cnt); end
        tick(1);
        nv++; if (l !== 1'b1) begin nf++; $display("FAIL tog_both_hold got %b want 1", l); end
        tick(2);
        sw = 2'b00;
        tick(10);
    endtask

    task automatic test_modes;
        logic [7:0] exp_a, exp_b;
        exp_a = 8'b00011001;
        exp_b = 8'b11100101;
        do_reset(3'd0);
        sw = 2'b10;
        tick(7);
        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            tick(1);
            nv++; if (l !== exp_a[m]) begin nf++; $display("FAIL mode%0d_sw10 got %b want %b", m, l, exp_a[m]); end
        end
        sw = 2'b11;
        tick(7);
        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            tick(1);
            nv++; if (l !== exp_b[m]) begin nf++; $display("FAIL mode%0d_sw11 got %b want %b", m, l, exp_b[m]); end
        end
    endtask

    task automatic test_saturate;
        do_reset(3'd7);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            sw = 2'b01;
            tick(10);
            sw = 2'b00;
            tick(10);
            nv++;
            if (cnt2 !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
                nf++; $display("FAIL sat_cnt2 pulse%0d got %0d want %0d", i, cnt2, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        nv++; if (cnt !== 8'd5) begin nf++; $display("FAIL cnt8_pulses got %0d want 5", cnt); end
        sw = 2'b01;
        tick(6);
        clr = 1'b1;
        tick(1);
        nv++; if (l2 !== 1'b1 || ep2 !== 1'b1) begin nf++; $display("FAIL clr_rise got l=%b e=%b want 1/1", l2, ep2); end
        nv++; if (cnt2 !== 2'd0) begin nf++; $display("FAIL clr_cnt2 got %0d want 0", cnt2); end
        nv++; if (cnt !== 8'd0) begin nf++; $display("FAIL clr_cnt got %0d want 0", cnt); end
        clr = 1'b0;
        tick(1);
        nv++; if (cnt2 !== 2'd0) begin nf++; $display("FAIL clr_after got %0d want 0", cnt2); end
        sw = 2'b00;
        tick(10);
    endtask

    task automatic test_reset_mid;
        do_reset(3'd0);
        sw = 2'b10;
        tick(7);
        nv++; if (sw_db !== 2'b10 || l !== 1'b1) begin nf++; $display("FAIL mid_pre got db=%b l=%b want 10/1", sw_db, l); end
        sw = 2'b11;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        nv++; if (sw_db !== 2'b00) begin nf++; $display("FAIL async_sw_db got %b want 00", sw_db); end
        nv++; if (l !== 1'b0 || ep !== 1'b0) begin nf++; $display("FAIL async_l got l=%b e=%b want 0/0", l, ep); end
        nv++; if (cnt !== 8'd0) begin nf++; $display("FAIL async_cnt got %0d want 0", cnt); end
        tick(2);
        rst_n = 1'b1;
        tick(5);
        nv++; if (sw_db !== 2'b00) begin nf++; $display("FAIL rel_early got %b want 00", sw_db); end
        tick(1);
        nv++; if (sw_db !== 2'b11) begin nf++; $display("FAIL rel_accept got %b want 11", sw_db); end
        tick(1);
        nv++; if (l !== 1'b1 || ep !== 1'b1 || cnt !== 8'd1) begin
            nf++; $display("FAIL rel_l got l=%b e=%b c=%0d want 1/1/1", l, ep, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_toggle();
        test_modes();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end

endmodule
